dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: port 0 is the CPU MEM stage and port 1 is the program/data loader or debug DMA.
- Issues one memory access per grant and sequences read latency with a small FSM.
- Returns read data with a valid pulse and drives a CPU stall while port 0 is waiting.
- Sits between the CPU data interface (data_addr/data_wen/data_write/data_read) and the data memory macro.

---
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
// Purpose : one requester port of the data-memory arbiter. It bundles the
//           request payload (req/wen/addr/wdata) with the grant and the
//           read-return channel (gnt/rvalid/rdata).
// Modports:
//   master - requester side (CPU MEM stage or loader/DMA). It drives the
//            request and receives gnt/rvalid/rdata.
//   slave  - arbiter side. It receives the request and drives
//            gnt/rvalid/rdata.
// Signals :
//   req    1   request; held with wen/addr/wdata stable until gnt
//   wen    1   1 = write, 0 = read
//   addr   AW  access address
//   wdata  DW  write data
//   gnt    1   grant, 1-cycle pulse in the issue cycle
//   rvalid 1   read data valid, 1-cycle pulse
//   rdata  DW  read data, holds its value between reads
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic          req;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req,
    output wen,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  wen,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Purpose : shares one single-port data memory between two requesters.
//           Port 0 is the CPU MEM stage and port 1 is the loader/debug DMA.
//           The arbiter issues one memory access per grant. A small FSM
//           sequences the read latency, and read data returns with a
//           one-cycle valid pulse. Port 0 has priority, but port 1 cannot
//           be starved for more than MAX_BURST consecutive port-0 grants.
// Ports   :
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   m0_if        if   port 0 (CPU) requester, slave modport
//   m1_if        if   port 1 (loader/DMA) requester, slave modport
//   o_m0_stall   out  CPU stall request (combinational)
//   o_mem_en     out  memory access strobe (combinational, issue cycle)
//   o_mem_wen    out  memory write enable (combinational)
//   o_mem_addr   out  memory address (combinational, 0 when idle)
//   o_mem_wdata  out  memory write data (combinational, 0 when idle)
//   i_mem_rdata  in   memory read data, valid RD_LAT cycles after issue
//   o_busy       out  1 while a read is outstanding (state RD_WAIT)
// Parameters:
//   AW, DW       address / data width
//   RD_LAT       memory read latency in cycles, 1..4
//   MAX_BURST    consecutive port-0 grants allowed while port 1 waits, 1..15
// ----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        m0_if,
  dmem_arbiter_if.slave        m1_if,
  output logic                 o_m0_stall,
  output logic                 o_mem_en,
  output logic                 o_mem_wen,
  output logic [AW-1:0]        o_mem_addr,
  output logic [DW-1:0]        o_mem_wdata,
  input  logic [DW-1:0]        i_mem_rdata,
  output logic                 o_busy
);

  localparam int unsigned LAT_W = 3;  // holds RD_LAT up to 4
  localparam int unsigned SC_W  = 4;  // starvation counter width

  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(1);
  localparam logic [SC_W-1:0]  SC_LIMIT  = SC_W'(MAX_BURST);
  localparam logic [SC_W-1:0]  SC_ONE    = SC_W'(1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [SC_W-1:0]   r_starve_cnt;
  logic              r_pend_port;    // port that owns the outstanding read
  logic              r_busy;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;
  logic [DW-1:0]     r_m0_rdata;
  logic [DW-1:0]     r_m1_rdata;

  // --------------------------------------------------------------------------
  // Issue-cycle decode
  // --------------------------------------------------------------------------
  logic w_can_issue;
  logic w_pick_m1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_issue;
  logic w_issue_wen;
  logic w_issue_rd;
  logic w_m0_rd_out;

  // Winner selection and combinational memory drive. Reset masks every
  // grant so that nothing reaches the memory while rst is high.
  always_comb begin
    w_can_issue = (r_state == S_IDLE) && !rst;
    // Port 1 wins when it is alone, or when port 0 has used up its burst.
    w_pick_m1   = m1_if.req && (!m0_if.req || (r_starve_cnt == SC_LIMIT));
    w_gnt1      = w_can_issue && w_pick_m1;
    w_gnt0      = w_can_issue && m0_if.req && !w_pick_m1;
    w_issue     = w_gnt0 || w_gnt1;

    w_issue_wen = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_gnt1) begin
      w_issue_wen = m1_if.wen;
      o_mem_addr  = m1_if.addr;
      o_mem_wdata = m1_if.wdata;
    end else if (w_gnt0) begin
      w_issue_wen = m0_if.wen;
      o_mem_addr  = m0_if.addr;
      o_mem_wdata = m0_if.wdata;
    end

    w_issue_rd  = w_issue && !w_issue_wen;
    o_mem_en    = w_issue;
    o_mem_wen   = w_issue_wen;
  end

  // A port-0 read counts as outstanding from its grant cycle until the data
  // returns. The CPU therefore keeps stalling through a read grant, but
  // stops stalling on a write grant.
  always_comb begin
    w_m0_rd_out = (w_gnt0 && !m0_if.wen) ||
                  ((r_state == S_RD_WAIT) && !r_pend_port);
    o_m0_stall  = !rst && ((m0_if.req && !w_gnt0) ||
                           (w_m0_rd_out && !r_m0_rvalid));
  end

  // --------------------------------------------------------------------------
  // Requester-facing outputs
  // --------------------------------------------------------------------------
  assign m0_if.gnt    = w_gnt0;
  assign m1_if.gnt    = w_gnt1;
  assign m0_if.rvalid = r_m0_rvalid;
  assign m1_if.rvalid = r_m1_rvalid;
  assign m0_if.rdata  = r_m0_rdata;
  assign m1_if.rdata  = r_m1_rdata;
  assign o_busy       = r_busy;

  // --------------------------------------------------------------------------
  // Read sequencer FSM, starvation counter and read-return registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_pend_port  <= 1'b0;
      r_busy       <= 1'b0;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      // rvalid is a single-cycle pulse
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;

      // Count port-0 wins while port 1 is waiting. Saturate at the burst limit.
      if (!m1_if.req || w_gnt1) begin
        r_starve_cnt <= '0;
      end else if (w_gnt0 && (r_starve_cnt < SC_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + SC_ONE;
      end

      case (r_state)
        S_IDLE: begin
          // Writes finish in the issue cycle. Only reads leave IDLE.
          if (w_issue_rd) begin
            r_state     <= S_RD_WAIT;
            r_busy      <= 1'b1;
            r_lat_cnt   <= LAT_INIT;
            r_pend_port <= w_gnt1;
          end
        end

        S_RD_WAIT: begin
          // When the counter reaches its last count, the memory data is
          // valid this cycle.
          if (r_lat_cnt == LAT_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_lat_cnt <= '0;
            if (r_pend_port) begin
              r_m1_rdata  <= i_mem_rdata;
              r_m1_rvalid <= 1'b1;
            end else begin
              r_m0_rdata  <= i_mem_rdata;
              r_m0_rvalid <= 1'b1;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_LAST;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
